// File: rtl/count_sequencer.sv
// Run/pause/step controller for a synchronous up counter: debounced buttons,
// switch-selected count-enable rate, optional one-shot stop at terminal carry.

module count_sequencer_btn #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int DW = $clog2(DEBOUNCE + 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [DW-1:0] cnt;

  // NOTE: reset is sampled on the clock edge, so it lives inside always_ff
  // and every state bit gets a defined value on the reset branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the synchronizer chain shift by
      // exactly one stage per edge regardless of statement order.
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // A single cycle of agreement restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module count_sequencer #(
  parameter int DIV0     = 50_000_000,
  parameter int DIV1     = 25_000_000,
  parameter int DIV2     = 12_500_000,
  parameter int DIV3     = 6_250_000,
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] RateSel,
  input  logic       BtnRun,
  input  logic       BtnStep,
  input  logic       Mode,
  input  logic       Carry,
  output logic       CountEn,
  output logic       CountClr,
  output logic [1:0] State
);
  localparam int MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int DMAX  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int PW    = $clog2(DMAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] div_last;
  logic [1:0]    rate_q;
  logic          run_press, step_press;
  logic          tick, rate_chg, stop_hit;

  count_sequencer_btn #(.DEBOUNCE(DEBOUNCE)) u_run (
    .clk   (Clk),
    .rst_n (Rst),
    .raw   (BtnRun),
    .press (run_press)
  );

  count_sequencer_btn #(.DEBOUNCE(DEBOUNCE)) u_step (
    .clk   (Clk),
    .rst_n (Rst),
    .raw   (BtnStep),
    .press (step_press)
  );

  always_comb begin
    case (RateSel)
      2'b00:   div_last = PW'(DIV0 - 1);
      2'b01:   div_last = PW'(DIV1 - 1);
      2'b10:   div_last = PW'(DIV2 - 1);
      default: div_last = PW'(DIV3 - 1);
    endcase
  end

  assign tick     = (presc == div_last);
  assign rate_chg = (RateSel != rate_q);
  assign stop_hit = Mode & Carry;
  assign State    = state;

  // Pulses default low every cycle; the prescaler defaults to 0 so it only
  // advances while RUN stays in RUN.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      CountEn  <= 1'b0;
      CountClr <= 1'b0;
      presc    <= '0;
      rate_q   <= 2'b00;
    end else begin
      rate_q   <= RateSel;
      CountEn  <= 1'b0;
      CountClr <= 1'b0;
      presc    <= '0;
      case (state)
        IDLE: begin
          if (run_press) begin
            state <= RUN;
          end else if (step_press) begin
            CountEn <= 1'b1;
            state   <= PAUSE;
          end
        end
        RUN: begin
          if (stop_hit) begin
            state <= DONE;
          end else if (run_press) begin
            state <= PAUSE;
          end else if (!rate_chg) begin
            if (tick) CountEn <= 1'b1;
            else      presc   <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (run_press) begin
            state <= RUN;
          end else if (step_press) begin
            if (stop_hit) state   <= DONE;
            else          CountEn <= 1'b1;
          end
        end
        DONE: begin
          if (run_press) begin
            CountClr <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with small dividers, a 3-bit counter
// model supplying Carry, and pulse tallies taken once per cycle.

module tb_count_sequencer;
  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] RateSel;
  logic       BtnRun, BtnStep, Mode;
  logic       Carry;
  logic       CountEn, CountClr;
  logic [1:0] State;

  logic [2:0] model_cnt;
  logic       model_clr;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int both_seen = 0;

  count_sequencer #(
    .DIV0(4), .DIV1(8), .DIV2(16), .DIV3(32), .DEBOUNCE(3)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RateSel  (RateSel),
    .BtnRun   (BtnRun),
    .BtnStep  (BtnStep),
    .Mode     (Mode),
    .Carry    (Carry),
    .CountEn  (CountEn),
    .CountClr (CountClr),
    .State    (State)
  );

  always #5 Clk = ~Clk;

  // Counter under control: counts on CountEn, clears on CountClr.
  always @(posedge Clk) begin
    if (model_clr || CountClr) model_cnt <= 3'd0;
    else if (CountEn)          model_cnt <= model_cnt + 3'd1;
  end
  assign Carry = (model_cnt == 3'd7);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: outputs sampled on the falling edge, pulses tallied there.
  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
    if (CountEn === 1'b1) en_cnt++;
    if (CountClr === 1'b1) clr_cnt++;
    if (CountEn === 1'b1 && CountClr === 1'b1) both_seen++;
  endtask

  int e0, c0, n;
  int step_pat [16] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    Rst = 1'b0; RateSel = 2'b00; BtnRun = 1'b0; BtnStep = 1'b0;
    Mode = 1'b0; model_clr = 1'b1;
    cycle(); cycle();

    // 1: idle after reset
    Rst = 1'b1; model_clr = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      check("reset_idle", {29'd0, State, CountEn, CountClr}, 32'd0);
    end

    // 2: run press latency and free-run rate 4
    BtnRun = 1'b1;
    repeat (6) cycle();
    check("run_lat_pre", State, 2'b00);
    cycle();
    check("run_lat", State, 2'b01);
    e0 = en_cnt;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (k == 3) BtnRun = 1'b0;
      check("run_tick", CountEn, (k % 4) == 0);
    end
    check("run_pulses", en_cnt - e0, 10);

    // 3: rate change restarts prescaler; then pause
    cycle();
    RateSel = 2'b11;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      check("rate_chg", CountEn, k == 33);
    end
    BtnRun = 1'b1;
    repeat (7) cycle();
    BtnRun = 1'b0;
    check("pause_enter", State, 2'b10);
    e0 = en_cnt;
    repeat (40) cycle();
    check("pause_quiet", en_cnt - e0, 0);
    check("pause_hold", State, 2'b10);

    // 4: bouncy step gives one pulse; simultaneous press resolves to run
    e0 = en_cnt;
    for (int k = 0; k < 16; k++) begin
      BtnStep = step_pat[k][0];
      cycle();
    end
    BtnStep = 1'b0;
    repeat (20) cycle();
    check("step_once", en_cnt - e0, 1);
    check("step_state", State, 2'b10);
    e0 = en_cnt;
    BtnRun = 1'b1; BtnStep = 1'b1;
    repeat (6) cycle();
    check("both_pre", State, 2'b10);
    cycle();
    check("both_run", State, 2'b01);
    repeat (3) cycle();
    BtnRun = 1'b0; BtnStep = 1'b0;
    check("both_nostep", en_cnt - e0, 0);
    repeat (10) cycle();

    // 5: one-shot stops at carry, run press clears
    BtnRun = 1'b1;
    repeat (7) cycle();
    BtnRun = 1'b0;
    check("os_pause", State, 2'b10);
    repeat (10) cycle();
    RateSel = 2'b00; Mode = 1'b1; model_clr = 1'b1;
    cycle();
    model_clr = 1'b0;
    e0 = en_cnt;
    BtnRun = 1'b1;
    repeat (7) cycle();
    BtnRun = 1'b0;
    check("os_run", State, 2'b01);
    n = 0;
    while (State !== 2'b11 && n < 200) begin
      cycle();
      n++;
    end
    check("os_done", State, 2'b11);
    check("os_pulses", en_cnt - e0, 7);
    check("os_model", model_cnt, 3'd7);
    repeat (20) cycle();
    check("os_no_8th", en_cnt - e0, 7);
    check("os_stay", State, 2'b11);
    c0 = clr_cnt;
    BtnRun = 1'b1;
    repeat (7) cycle();
    BtnRun = 1'b0;
    check("clr_idle", State, 2'b00);
    check("clr_pulse", clr_cnt - c0, 1);
    cycle();
    check("clr_model", model_cnt, 3'd0);
    check("clr_single", clr_cnt - c0, 1);
    repeat (10) cycle();

    // 6: reset on the edge a tick is due
    Mode = 1'b0;
    BtnRun = 1'b1;
    repeat (7) cycle();
    BtnRun = 1'b0;
    check("rst_run", State, 2'b01);
    n = 0;
    while (CountEn !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_tick_seen", CountEn, 1'b1);
    repeat (3) cycle();
    Rst = 1'b0;
    cycle();
    check("rst_abort", {29'd0, State, CountEn, CountClr}, 32'd0);
    cycle();
    check("rst_hold", {29'd0, State, CountEn, CountClr}, 32'd0);
    Rst = 1'b1;
    repeat (5) cycle();
    check("rst_after", {29'd0, State, CountEn, CountClr}, 32'd0);

    check("never_both", both_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Run/pause/step controller for the synchronous up counter on the single fast board clock.
- Generates one-cycle count-enable pulses at a switch-selected rate, which replaces the divided-clock mux.
- Debounces the run and step buttons, and optionally stops at the counter's terminal carry (one-shot mode).
- Sits between the board switches/buttons and the counter's En/clear inputs. The counter is clocked by the same Clk.

Parameters:
DIV0, 50_000_000, Clk cycles per CountEn pulse for RateSel=00
DIV1, 25_000_000, Clk cycles per CountEn pulse for RateSel=01
DIV2, 12_500_000, Clk cycles per CountEn pulse for RateSel=10
DIV3, 6_250_000, Clk cycles per CountEn pulse for RateSel=11
DEBOUNCE, 1_000_000, consecutive stable Clk cycles required before a button level is accepted (all DIVn >= 2, DEBOUNCE >= 1)

Ports:
Clk  input  1  single system clock; all state updates on rising edge
Rst  input  1  synchronous reset, active-low
RateSel  input  2  tick-rate select (switches)
BtnRun  input  1  raw run/pause button, asynchronous, active-high
BtnStep  input  1  raw single-step button, asynchronous, active-high
Mode  input  1  0 = free-run with wrap, 1 = one-shot, stop at Carry
Carry  input  1  counter terminal flag, high while the count is at its maximum
CountEn  output  1  one-cycle enable pulse to the counter
CountClr  output  1  one-cycle synchronous clear pulse to the counter
State  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
Reset
- Rst=0 at a Clk edge forces State=IDLE, CountEn=0, CountClr=0, prescaler=0.
- Reset also clears the synchronizers, debounced levels, debounce counters and edge pulses.
- Reset mid-run aborts immediately; no pulse is emitted on that edge.

Button path (identical for both buttons)
- Raw input passes through a 2-FF synchronizer.
- Debounced level flips once the synchronized value has differed from it for DEBOUNCE consecutive cycles.
- Any bounce restarts the debounce count.
- A press pulse is registered one cycle after the debounced level rises. There is no action on release.
- Total latency: DEBOUNCE+3 edges from the first edge sampling the raw button high to the press pulse. The FSM output follows one edge later.

Prescaler
- Counts only in RUN; held at 0 in every other state.
- Reloads to 0 on any cycle where RateSel differs from its value registered on the previous cycle.
- On reaching DIVsel-1 it produces a tick and wraps to 0.
- RateSel is sampled directly; the switches are treated as quasi-static.

FSM (registered outputs; all pulses are exactly 1 cycle)
- IDLE:
  - run press -> RUN.
  - step press -> CountEn pulse, -> PAUSE.
- RUN:
  - tick -> CountEn pulse.
  - run press -> PAUSE; a tick in the same cycle is suppressed.
  - Mode=1 and Carry=1 -> DONE, with no CountEn in that cycle. This check has priority over tick.
- PAUSE:
  - run press -> RUN, prescaler starting from 0.
  - step press -> CountEn pulse.
  - Mode=1 and Carry=1 at a step press -> DONE, no pulse.
- DONE:
  - No CountEn.
  - run press -> CountClr pulse, -> IDLE.
  - step press is ignored.
- Simultaneous run and step press: run wins and step is dropped.
- Step presses in RUN are ignored.
- Mode=0: Carry is ignored and the counter wraps naturally.
- CountEn and CountClr are never high together.

Test Plan:
(Bench parameters: DIV0=4, DIV1=8, DIV2=16, DIV3=32, DEBOUNCE=3.)
1. Rst=0 for 2 cycles, then Rst=1 with buttons low -> State=00, CountEn=0, CountClr=0 for 50 cycles.
2. BtnRun held high 10 cycles, RateSel=00, Mode=0 -> State=01 exactly 7 edges after the press. CountEn then pulses every 4 cycles, 10 pulses in 40 cycles.
3. In RUN, RateSel switched 00->11 mid-period -> prescaler restarts and the next CountEn arrives 32 cycles after the change. Then a second run press -> State=10 with no further pulses.
4. PAUSE, BtnStep press with 2 bounce glitches (1-cycle low) inside the debounce window -> exactly one CountEn pulse. Simultaneous BtnRun+BtnStep press -> State=01, no step pulse.
5. Mode=1, RUN at RateSel=00 with a counter model driving Carry at count 7 -> 7 pulses, then State=11 with no 8th pulse. A run press then gives one CountClr pulse and State=00.
6. Rst=0 asserted on the cycle a tick is due -> no CountEn that edge, all outputs 0 on the next edge.
